ysyx_22050598_lsu: RTL and testbench
====================================

YSYX_22050598_LSU -- requirements
Module: ysyx_22050598_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; there are no parameters.
REQ-002 clk  in  1  sole clock, all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 lsu_valid_i  in  1  execute stage offers a load/store request.
REQ-005 lsu_ready_o  out  1  LSU can accept a request; high only in IDLE.
REQ-006 lsu_is_store_i  in  1  1 = store, 0 = load.
REQ-007 lsu_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-008 lsu_unsigned_i  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-009 lsu_addr_i  in  64  effective byte address.
REQ-010 lsu_wdata_i  in  64  store data, right-aligned.
REQ-011 mem_req_valid_o  out  1  bus request valid.
REQ-012 mem_req_ready_i  in  1  bus accepts the request.
REQ-013 mem_req_addr_o  out  64  address with bits [2:0] forced to 0.
REQ-014 mem_req_wen_o  out  1  write enable.
REQ-015 mem_req_wdata_o  out  64  lane-shifted store data.
REQ-016 mem_req_wstrb_o  out  8  byte strobes; 0 for loads.
REQ-017 mem_resp_valid_i  in  1  read data or write acknowledge.
REQ-018 mem_resp_rdata_i  in  64  raw 64-bit read beat.
REQ-019 lsu_done_valid_o  out  1  result available to writeback.
REQ-020 lsu_done_ready_i  in  1  writeback consumes the result.
REQ-021 lsu_rdata_o  out  64  formatted load result; 0 for stores and misaligned accesses.
REQ-022 lsu_misalign_o  out  1  access was misaligned; valid when lsu_done_valid_o is high.

Function
REQ-023 The FSM SHALL have the states IDLE, REQ, RESP and DONE.
REQ-024 IDLE: on lsu_valid_i && lsu_ready_o, register the address, data, size, store flag and unsigned flag.
 - If the access is misaligned, go to DONE with misalign=1.
 - Otherwise go to REQ.
REQ-025 Misaligned means addr[0]!=0 for half, addr[1:0]!=0 for word, or addr[2:0]!=0 for double; a misaligned access SHALL issue no bus request.
REQ-026 REQ: drive mem_req_valid_o=1 with all mem_req_* held stable until mem_req_ready_i; on the handshake, go to RESP.
REQ-027 RESP: wait for mem_resp_valid_i; on it, register the formatted result and go to DONE. Stores also wait for this write acknowledge.
REQ-028 mem_resp_valid_i outside RESP SHALL be ignored.
REQ-029 DONE: drive lsu_done_valid_o=1 with the outputs stable until lsu_done_ready_i; then go to IDLE. There is no IDLE bypass in the same cycle.
REQ-030 Minimum latency: with request accepted at T, mem_req_ready_i=1 at T+1 and mem_resp_valid_i=1 at T+2, done_valid is asserted at T+3. A misaligned access gives done_valid at T+1.
REQ-031 Store lanes: off=addr[2:0]; wdata = lsu_wdata_i << (8*off); wstrb = {01,03,0F,FF}[size] << off, truncated to 8 bits.
REQ-032 Load format: the field is rdata[8*off +: 8<<size]; it is sign-extended or zero-extended per lsu_unsigned_i. A double load is returned unchanged.

Reset
REQ-033 On rst: state=IDLE, lsu_ready_o=1, and all other outputs and registered fields = 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no bus retry after release.

Structure
REQ-035 The shared package (defines) SHALL hold the size codes B/H/W/D (00/01/10/11) and the LSU state encodings.
REQ-036 The load extract/extend logic SHALL be one sub-module, ysyx_22050598_lsu_ldfmt (combinational).

Verification
REQ-037 Load byte, sign-extended: addr=0x8000_0003, size=00, unsigned=0, rdata=0x0000_0000_8000_0000 -> req addr 0x8000_0000, wstrb 0x00, lsu_rdata_o=0xFFFF_FFFF_FFFF_FF80.
REQ-038 Load word, zero-extended: addr=0x8000_0004, size=10, unsigned=1, rdata=0xDEAD_BEEF_0000_0000 -> lsu_rdata_o=0x0000_0000_DEAD_BEEF.
REQ-039 Store half: addr=0x8000_0006, wdata=0x1234, size=01 -> wen=1, wstrb=0xC0, wdata=0x1234_0000_0000_0000, lsu_rdata_o=0.
REQ-040 Misaligned double: addr=0x8000_0004, size=11 -> no mem_req_valid_o, done_valid one cycle after accept, misalign=1.
REQ-041 Backpressure: mem_req_ready_i low for 3 cycles and lsu_done_ready_i low for 2 cycles -> request and result held stable, lsu_ready_o=0 throughout.
REQ-042 rst pulse while in RESP -> next cycle IDLE, all outputs 0 with lsu_ready_o=1, and the late mem_resp_valid_i is ignored.

Source files
------------

// File: rtl/ysyx_22050598_lsu_pkg.sv
// Shared definitions for the LSU: access size codes, FSM state encoding and
// small lane helpers used by the top and the load formatter.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package ysyx_22050598_lsu_pkg;

  // Access size codes as carried on lsu_size_i.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // An access is aligned when the low address bits below its size are zero.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic w_mis;
    case (size)
      SZ_B:    w_mis = 1'b0;
      SZ_H:    w_mis = off[0];
      SZ_W:    w_mis = |off[1:0];
      default: w_mis = |off;
    endcase
    return w_mis;
  endfunction

  // Byte strobes for a store; shifting an 8-bit base truncates to the beat.
  function automatic logic [7:0] strb_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] w_base;
    case (size)
      SZ_B:    w_base = 8'h01;
      SZ_H:    w_base = 8'h03;
      SZ_W:    w_base = 8'h0F;
      default: w_base = 8'hFF;
    endcase
    return w_base << off;
  endfunction

endpackage

// File: rtl/ysyx_22050598_lsu_ldfmt.sv
// Load formatter: extracts the addressed field from a raw 64-bit read beat and
// sign- or zero-extends it to 64 bits.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_rdata raw beat, i_off byte offset, i_size access size,
//        i_unsigned zero-extend when 1, o_data formatted result.
module ysyx_22050598_lsu_ldfmt
  import ysyx_22050598_lsu_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic [63:0] w_shift;

  // Move the addressed byte lane down to bit 0 before picking the field.
  assign w_shift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_B: o_data = i_unsigned ? {56'd0, w_shift[7:0]}
                                : {{56{w_shift[7]}}, w_shift[7:0]};
      SZ_H: o_data = i_unsigned ? {48'd0, w_shift[15:0]}
                                : {{48{w_shift[15]}}, w_shift[15:0]};
      SZ_W: o_data = i_unsigned ? {32'd0, w_shift[31:0]}
                                : {{32{w_shift[31]}}, w_shift[31:0]};
      // Only aligned doubles reach here, so the shift is zero and the beat
      // passes through unchanged.
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/ysyx_22050598_lsu.sv
// Load/store unit: accepts one execute-stage request, issues one aligned bus
// beat, formats the response and hands the result to writeback.
// Latency: 3 cycles accept-to-done with zero-wait bus; 1 cycle for misaligned.
// Backpressure: ready only in IDLE; request and result held until handshaken.
// Ports: lsu_* execute/writeback side, mem_req_* / mem_resp_* bus side,
//        clk single clock, rst asynchronous active-high reset.
module ysyx_22050598_lsu
  import ysyx_22050598_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_is_store_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [63:0] lsu_addr_i,
  input  logic [63:0] lsu_wdata_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [63:0] mem_req_addr_o,
  output logic        mem_req_wen_o,
  output logic [63:0] mem_req_wdata_o,
  output logic [7:0]  mem_req_wstrb_o,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_resp_rdata_i,
  output logic        lsu_done_valid_o,
  input  logic        lsu_done_ready_i,
  output logic [63:0] lsu_rdata_o,
  output logic        lsu_misalign_o
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;

  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic [1:0]  r_size;
  logic        r_store;
  logic        r_unsigned;
  logic        r_misalign;

  logic        w_accept;
  logic        w_resp_take;
  logic        w_in_misal;
  logic [2:0]  w_off;
  logic [63:0] w_ld_data;

  assign w_in_misal = is_misaligned(lsu_size_i, lsu_addr_i[2:0]);
  assign w_off      = r_addr[2:0];

  ysyx_22050598_lsu_ldfmt u_ldfmt (
    .i_rdata    (mem_resp_rdata_i),
    .i_off      (w_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_resp_take      = 1'b0;
    lsu_ready_o      = 1'b0;
    mem_req_valid_o  = 1'b0;
    lsu_done_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        lsu_ready_o = 1'b1;
        if (lsu_valid_i) begin
          w_accept = 1'b1;
          // Misaligned accesses never touch the bus.
          w_state_nxt = w_in_misal ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Stores also wait here for their write acknowledge.
        if (mem_resp_valid_i) begin
          w_resp_take = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        lsu_done_valid_o = 1'b1;
        if (lsu_done_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_size     <= SZ_B;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= lsu_addr_i;
        r_wdata    <= lsu_wdata_i;
        r_size     <= lsu_size_i;
        r_store    <= lsu_is_store_i;
        r_unsigned <= lsu_unsigned_i;
        r_misalign <= w_in_misal;
        r_rdata    <= '0;
      end
      if (w_resp_take) begin
        r_rdata <= r_store ? 64'd0 : w_ld_data;
      end
    end
  end

  // Bus outputs are qualified by the request state so the bus sees zeros
  // whenever no request is outstanding.
  assign mem_req_addr_o  = mem_req_valid_o ? {r_addr[63:3], 3'b000} : 64'd0;
  assign mem_req_wen_o   = mem_req_valid_o & r_store;
  assign mem_req_wdata_o = (mem_req_valid_o && r_store) ? (r_wdata << {w_off, 3'b000}) : 64'd0;
  assign mem_req_wstrb_o = (mem_req_valid_o && r_store) ? strb_mask(r_size, w_off) : 8'd0;

  assign lsu_rdata_o     = lsu_done_valid_o ? r_rdata : 64'd0;
  assign lsu_misalign_o  = lsu_done_valid_o & r_misalign;

endmodule

// File: tb/tb_ysyx_22050598_lsu.sv
module tb_ysyx_22050598_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        lsu_is_store_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic [63:0] lsu_addr_i;
  logic [63:0] lsu_wdata_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_req_wen_o;
  logic [63:0] mem_req_wdata_o;
  logic [7:0]  mem_req_wstrb_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_rdata_i;
  logic        lsu_done_valid_o;
  logic        lsu_done_ready_i;
  logic [63:0] lsu_rdata_o;
  logic        lsu_misalign_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ysyx_22050598_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_valid_i      (lsu_valid_i),
    .lsu_ready_o      (lsu_ready_o),
    .lsu_is_store_i   (lsu_is_store_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_unsigned_i   (lsu_unsigned_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_wen_o    (mem_req_wen_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_req_wstrb_o  (mem_req_wstrb_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_rdata_i (mem_resp_rdata_i),
    .lsu_done_valid_o (lsu_done_valid_o),
    .lsu_done_ready_i (lsu_done_ready_i),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_misalign_o   (lsu_misalign_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte-count arithmetic straight from the access rules.
  function automatic logic m_misal(input logic [1:0] sz, input logic [2:0] off);
    int nbytes;
    nbytes = 1 << int'(sz);
    return (int'(off) % nbytes) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [1:0] sz, input logic [2:0] off);
    int nbytes;
    int m;
    nbytes = 1 << int'(sz);
    m = ((1 << nbytes) - 1) << int'(off);
    return 8'(m & 255);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] off,
                                         input logic [1:0] sz, input logic uns);
    int nbits;
    logic [63:0] f;
    logic [63:0] mask;
    nbits = 8 << int'(sz);
    f = rd >> (8 * int'(off));
    if (nbits < 64) begin
      mask = (64'd1 << nbits) - 64'd1;
      f = f & mask;
      if (!uns && f[nbits-1]) f = f | ~mask;
    end
    return f;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_txn(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input int req_stall, input int done_stall);
    logic [2:0]  off;
    logic        mis;
    logic [63:0] exp_rd;
    off    = addr[2:0];
    mis    = m_misal(sz, off);
    exp_rd = (mis || st) ? 64'd0 : m_load(rd, off, sz, uns);

    @(negedge clk);
    chk("idle_ready", lsu_ready_o, 1);
    lsu_valid_i    = 1'b1;
    lsu_is_store_i = st;
    lsu_size_i     = sz;
    lsu_unsigned_i = uns;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wd;
    @(negedge clk);
    // Scramble request inputs: the LSU must work from its registered copy.
    lsu_valid_i = 1'b0;
    lsu_addr_i  = rnd64();
    lsu_wdata_i = rnd64();
    lsu_size_i  = 2'($urandom);

    if (!mis) begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("req_valid", mem_req_valid_o, 1);
        chk("req_addr", mem_req_addr_o, addr & ~64'd7);
        chk("req_wen", mem_req_wen_o, st);
        chk("req_wstrb", mem_req_wstrb_o, st ? m_strb(sz, off) : 8'd0);
        if (st) chk("req_wdata", mem_req_wdata_o, wd << (8 * int'(off)));
        chk("req_busy", lsu_ready_o, 0);
        chk("req_nodone", lsu_done_valid_o, 0);
        if (i == req_stall) begin
          mem_req_ready_i  = 1'b1;
          mem_resp_valid_i = 1'b0;
        end else begin
          mem_req_ready_i  = 1'b0;
          mem_resp_valid_i = 1'($urandom);
          mem_resp_rdata_i = rnd64();
        end
        @(negedge clk);
      end
      mem_req_ready_i = 1'b0;
      chk("resp_noreq", mem_req_valid_o, 0);
      chk("resp_nodone", lsu_done_valid_o, 0);
      mem_resp_valid_i = 1'b1;
      mem_resp_rdata_i = rd;
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
    end else begin
      chk("mis_noreq", mem_req_valid_o, 0);
    end

    for (int i = 0; i <= done_stall; i++) begin
      chk("done_valid", lsu_done_valid_o, 1);
      chk("done_rdata", lsu_rdata_o, exp_rd);
      chk("done_misal", lsu_misalign_o, mis);
      chk("done_noreq", mem_req_valid_o, 0);
      chk("done_busy", lsu_ready_o, 0);
      if (i == done_stall) begin
        lsu_done_ready_i = 1'b1;
        mem_resp_valid_i = 1'b0;
      end else begin
        lsu_done_ready_i = 1'b0;
        mem_resp_valid_i = 1'($urandom);
        mem_resp_rdata_i = rnd64();
      end
      @(negedge clk);
    end
    lsu_done_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    chk("back_idle", lsu_ready_o, 1);
    chk("back_nodone", lsu_done_valid_o, 0);
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_ready"}, lsu_ready_o, 1);
    chk({tag, "_reqv"}, mem_req_valid_o, 0);
    chk({tag, "_addr"}, mem_req_addr_o, 0);
    chk({tag, "_wen"}, mem_req_wen_o, 0);
    chk({tag, "_wdata"}, mem_req_wdata_o, 0);
    chk({tag, "_wstrb"}, mem_req_wstrb_o, 0);
    chk({tag, "_done"}, lsu_done_valid_o, 0);
    chk({tag, "_rdata"}, lsu_rdata_o, 0);
    chk({tag, "_misal"}, lsu_misalign_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    lsu_valid_i      = 1'b0;
    lsu_is_store_i   = 1'b0;
    lsu_size_i       = 2'b00;
    lsu_unsigned_i   = 1'b0;
    lsu_addr_i       = '0;
    lsu_wdata_i      = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = '0;
    lsu_done_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_idle("rst");
    rst = 1'b0;

    // Directed cases.
    run_txn(1'b0, 2'b00, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    run_txn(1'b0, 2'b10, 1'b1, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 0);
    run_txn(1'b1, 2'b01, 1'b0, 64'h8000_0006, 64'h1234, 64'd0, 0, 0);
    run_txn(1'b0, 2'b11, 1'b0, 64'h8000_0004, 64'd0, 64'd0, 0, 0);
    run_txn(1'b0, 2'b11, 1'b0, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 2);
    run_txn(1'b1, 2'b10, 1'b0, 64'h8000_0005, 64'hFFFF_FFFF, 64'd0, 0, 2);

    // Reset while waiting for the response.
    @(negedge clk);
    lsu_valid_i    = 1'b1;
    lsu_is_store_i = 1'b0;
    lsu_size_i     = 2'b10;
    lsu_addr_i     = 64'h8000_0010;
    @(negedge clk);
    lsu_valid_i     = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    chk("pre_rst_resp", mem_req_valid_o, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_ready", lsu_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    chk_all_idle("midrst");
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = rnd64();
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    chk_all_idle("late_resp");
    @(negedge clk);
    chk("no_retry", mem_req_valid_o, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a;
      a = rnd64();
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), a, rnd64(), rnd64(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
